// File: rtl/haze_frame_sequencer.sv
// ---------------------------------------------------------------------------
// haze_frame_sequencer
//   Two-pass frame controller for the dehaze pipeline.
//   Pass 1 streams every frame-buffer address in raster order into the
//   atmospheric light estimator (ALE). It then waits for the ALE done flag
//   plus its output latency, and latches A and 1/A. Pass 2 re-streams the
//   frame to the recovery stage under dh_ready backpressure, with the
//   latched A held constant.
//
// Ports
//   i_clk          clock
//   i_rst          asynchronous active-low reset
//   i_start        frame start request (sampled in IDLE only)
//   i_abort        return to IDLE from any busy state
//   o_rd_en        frame buffer read enable
//   o_rd_addr      raster read address
//   o_ale_rst      one-cycle active-high reset pulse to the ALE
//   o_ale_valid    pass-1 rd_en delayed RD_LAT cycles
//   i_ale_done     ALE all-pixels-processed flag
//   i_ale_a_*      ALE atmospheric light (8b per channel)
//   i_ale_inv_*    ALE reciprocals, Q0.14
//   o_a_*          latched atmospheric light
//   o_inv_a_*      latched reciprocals
//   i_dh_ready     recovery stage can accept an issue this cycle
//   o_dh_valid     pass-2 rd_en delayed RD_LAT cycles
//   o_busy         high in every state except IDLE
//   o_pass2        high in DEHAZE and DH_DRAIN
//   o_frame_done   one-cycle pulse at frame completion
//   o_ale_err      sticky ALE timeout flag, cleared on accepted start
// ---------------------------------------------------------------------------
module haze_frame_sequencer #(
    parameter int IMG_W   = 512,
    parameter int IMG_H   = 512,
    parameter int ADDR_W  = 18,
    parameter int RD_LAT  = 1,
    parameter int ALE_LAT = 2,
    parameter int TIMEOUT = 16
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic              i_abort,
    output logic              o_rd_en,
    output logic [ADDR_W-1:0] o_rd_addr,
    output logic              o_ale_rst,
    output logic              o_ale_valid,
    input  logic              i_ale_done,
    input  logic [7:0]        i_ale_a_r,
    input  logic [7:0]        i_ale_a_g,
    input  logic [7:0]        i_ale_a_b,
    input  logic [13:0]       i_ale_inv_r,
    input  logic [13:0]       i_ale_inv_g,
    input  logic [13:0]       i_ale_inv_b,
    output logic [7:0]        o_a_r,
    output logic [7:0]        o_a_g,
    output logic [7:0]        o_a_b,
    output logic [13:0]       o_inv_a_r,
    output logic [13:0]       o_inv_a_g,
    output logic [13:0]       o_inv_a_b,
    input  logic              i_dh_ready,
    output logic              o_dh_valid,
    output logic              o_busy,
    output logic              o_pass2,
    output logic              o_frame_done,
    output logic              o_ale_err
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMG_W * IMG_H - 1);
    localparam int TW   = $clog2(TIMEOUT + 1);
    localparam int MAXL = (ALE_LAT > RD_LAT) ? ALE_LAT : RD_LAT;
    localparam int DW   = $clog2(MAXL + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ALE_PASS,
        S_ALE_WAIT,
        S_ALE_DRAIN,
        S_DEHAZE,
        S_DH_DRAIN
    } state_t;

    state_t              r_state;
    logic [ADDR_W-1:0]   r_addr;
    logic [TW-1:0]       r_tcnt;
    logic [DW-1:0]       r_dcnt;
    logic                r_ale_rst;
    logic                r_frame_done;
    logic                r_ale_err;
    logic [7:0]          r_a_r, r_a_g, r_a_b;
    logic [13:0]         r_inv_r, r_inv_g, r_inv_b;
    logic [RD_LAT-1:0]   r_ale_pipe;
    logic [RD_LAT-1:0]   r_dh_pipe;

    logic w_abort;
    logic w_issue;
    logic w_last;

    // abort only has meaning while busy; in IDLE a concurrent start wins
    assign w_abort = i_abort && (r_state != S_IDLE);
    // Read issue is combinational so pass-2 reads follow dh_ready in the
    // same cycle and an abort suppresses the read it coincides with.
    assign w_issue = !w_abort &&
                     ((r_state == S_ALE_PASS) ||
                      ((r_state == S_DEHAZE) && i_dh_ready));
    assign w_last  = (r_addr == LAST_ADDR);

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state      <= S_IDLE;
            r_addr       <= '0;
            r_tcnt       <= '0;
            r_dcnt       <= '0;
            r_ale_rst    <= 1'b0;
            r_frame_done <= 1'b0;
            r_ale_err    <= 1'b0;
            r_a_r        <= '0;
            r_a_g        <= '0;
            r_a_b        <= '0;
            r_inv_r      <= '0;
            r_inv_g      <= '0;
            r_inv_b      <= '0;
        end else begin
            r_ale_rst    <= 1'b0;
            r_frame_done <= 1'b0;
            if (w_abort) begin
                r_state <= S_IDLE;
                r_addr  <= '0;
                r_tcnt  <= '0;
                r_dcnt  <= '0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (i_start) begin
                            r_ale_rst <= 1'b1;
                            r_ale_err <= 1'b0;
                            r_addr    <= '0;
                            r_state   <= S_ALE_PASS;
                        end
                    end
                    S_ALE_PASS: begin
                        if (w_last) begin
                            r_addr  <= '0;
                            r_tcnt  <= '0;
                            r_state <= S_ALE_WAIT;
                        end else begin
                            r_addr <= r_addr + ADDR_W'(1);
                        end
                    end
                    S_ALE_WAIT: begin
                        // The last-address cycle is the first of the TIMEOUT
                        // cycles, so ale_err lands exactly TIMEOUT cycles
                        // after that address was issued.
                        if (i_ale_done) begin
                            r_dcnt  <= '0;
                            r_state <= S_ALE_DRAIN;
                        end else if (r_tcnt == TW'(TIMEOUT - 2)) begin
                            r_ale_err <= 1'b1;
                            r_state   <= S_IDLE;
                        end else begin
                            r_tcnt <= r_tcnt + TW'(1);
                        end
                    end
                    S_ALE_DRAIN: begin
                        // Sample the estimator on the ALE_LAT-th cycle after
                        // done was first seen, when its outputs are final.
                        if (r_dcnt == DW'(ALE_LAT - 1)) begin
                            r_a_r   <= i_ale_a_r;
                            r_a_g   <= i_ale_a_g;
                            r_a_b   <= i_ale_a_b;
                            r_inv_r <= i_ale_inv_r;
                            r_inv_g <= i_ale_inv_g;
                            r_inv_b <= i_ale_inv_b;
                            r_dcnt  <= '0;
                            r_state <= S_DEHAZE;
                        end else begin
                            r_dcnt <= r_dcnt + DW'(1);
                        end
                    end
                    S_DEHAZE: begin
                        if (w_issue) begin
                            if (w_last) begin
                                r_addr  <= '0;
                                r_dcnt  <= '0;
                                r_state <= S_DH_DRAIN;
                            end else begin
                                r_addr <= r_addr + ADDR_W'(1);
                            end
                        end
                    end
                    S_DH_DRAIN: begin
                        // frame_done follows the final dh_valid by one cycle
                        if (r_dcnt == DW'(RD_LAT - 1)) begin
                            r_frame_done <= 1'b1;
                            r_dcnt       <= '0;
                            r_state      <= S_IDLE;
                        end else begin
                            r_dcnt <= r_dcnt + DW'(1);
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    // Valid delay lines, one per pass; abort flushes anything in flight.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_ale_pipe <= '0;
            r_dh_pipe  <= '0;
        end else if (w_abort) begin
            r_ale_pipe <= '0;
            r_dh_pipe  <= '0;
        end else begin
            r_ale_pipe[0] <= w_issue && (r_state == S_ALE_PASS);
            r_dh_pipe[0]  <= w_issue && (r_state == S_DEHAZE);
            for (int i = 1; i < RD_LAT; i++) begin
                r_ale_pipe[i] <= r_ale_pipe[i-1];
                r_dh_pipe[i]  <= r_dh_pipe[i-1];
            end
        end
    end

    assign o_rd_en      = w_issue;
    assign o_rd_addr    = r_addr;
    assign o_ale_rst    = r_ale_rst;
    assign o_ale_valid  = r_ale_pipe[RD_LAT-1];
    assign o_dh_valid   = r_dh_pipe[RD_LAT-1];
    assign o_busy       = (r_state != S_IDLE);
    assign o_pass2      = (r_state == S_DEHAZE) || (r_state == S_DH_DRAIN);
    assign o_frame_done = r_frame_done;
    assign o_ale_err    = r_ale_err;
    assign o_a_r        = r_a_r;
    assign o_a_g        = r_a_g;
    assign o_a_b        = r_a_b;
    assign o_inv_a_r    = r_inv_r;
    assign o_inv_a_g    = r_inv_g;
    assign o_inv_a_b    = r_inv_b;

endmodule

// File: tb/tb_haze_frame_sequencer.sv
// ---------------------------------------------------------------------------
// tb_haze_frame_sequencer
//   Directed bench for a 4x4 frame: normal two-pass frame with toggling
//   dh_ready and ignored start pulses, ALE timeout, pass-2 abort, start with
//   abort in IDLE, and asynchronous reset mid pass 1. A cycle-stamped model
//   checks every output every cycle; literal expectations pin the model.
// ---------------------------------------------------------------------------
module tb_haze_frame_sequencer;

    localparam int IMG_W   = 4;
    localparam int IMG_H   = 4;
    localparam int ADDR_W  = 4;
    localparam int RD_LAT  = 1;
    localparam int ALE_LAT = 2;
    localparam int TIMEOUT = 16;
    localparam int NPIX    = IMG_W * IMG_H;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, start, abort, dh_ready, ale_done;
    logic [7:0]  ale_a_r, ale_a_g, ale_a_b;
    logic [13:0] ale_inv_r, ale_inv_g, ale_inv_b;
    logic rd_en, ale_rst, ale_valid, dh_valid, busy, pass2, frame_done, ale_err;
    logic [ADDR_W-1:0] rd_addr;
    logic [7:0]  a_r, a_g, a_b;
    logic [13:0] inv_a_r, inv_a_g, inv_a_b;

    haze_frame_sequencer #(
        .IMG_W(IMG_W), .IMG_H(IMG_H), .ADDR_W(ADDR_W),
        .RD_LAT(RD_LAT), .ALE_LAT(ALE_LAT), .TIMEOUT(TIMEOUT)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_abort(abort),
        .o_rd_en(rd_en), .o_rd_addr(rd_addr), .o_ale_rst(ale_rst),
        .o_ale_valid(ale_valid), .i_ale_done(ale_done),
        .i_ale_a_r(ale_a_r), .i_ale_a_g(ale_a_g), .i_ale_a_b(ale_a_b),
        .i_ale_inv_r(ale_inv_r), .i_ale_inv_g(ale_inv_g), .i_ale_inv_b(ale_inv_b),
        .o_a_r(a_r), .o_a_g(a_g), .o_a_b(a_b),
        .o_inv_a_r(inv_a_r), .o_inv_a_g(inv_a_g), .o_inv_a_b(inv_a_b),
        .i_dh_ready(dh_ready), .o_dh_valid(dh_valid), .o_busy(busy),
        .o_pass2(pass2), .o_frame_done(frame_done), .o_ale_err(ale_err)
    );

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // ALE stand-in: done one cycle after the 16th valid, final values
    // ALE_LAT cycles after done rises, random junk at all other times.
    bit en_done = 1'b1;
    initial begin
        int e_cnt, e_age;
        e_cnt = 0; e_age = 0; ale_done = 1'b0;
        ale_a_r = '0; ale_a_g = '0; ale_a_b = '0;
        ale_inv_r = '0; ale_inv_g = '0; ale_inv_b = '0;
        forever begin
            @(negedge clk);
            if (ale_rst) begin
                e_cnt = 0; e_age = 0; ale_done = 1'b0;
            end else begin
                if (ale_done) e_age++;
                if (e_cnt == NPIX && en_done && !ale_done) begin
                    ale_done = 1'b1; e_age = 0;
                end
                if (ale_valid) e_cnt++;
            end
            if (ale_done && e_age >= ALE_LAT) begin
                ale_a_r = 8'd200; ale_a_g = 8'd180; ale_a_b = 8'd160;
                ale_inv_r = 14'd82; ale_inv_g = 14'd91; ale_inv_b = 14'd102;
            end else begin
                ale_a_r = 8'($urandom); ale_a_g = 8'($urandom); ale_a_b = 8'($urandom);
                ale_inv_r = 14'($urandom); ale_inv_g = 14'($urandom); ale_inv_b = 14'($urandom);
            end
        end
    end

    // Observations used by the literal checks
    int mon_rst_cnt = 0, mon_p1_cnt = 0, mon_p1_first = 0, mon_p1_last = 0;
    int mon_dh_cnt = 0, mon_dh_last = 0, mon_fd_cnt = 0, mon_fd_last = 0;
    int mon_err_rise = 0, mon_done_first = 0, mon_latch_cyc = 0;
    int p2_hits[NPIX];
    bit prev_err = 1'b0, prev_done = 1'b0;
    logic [7:0] prev_a_r = '0;

    // Model: phase of the frame plus cycle stamps of the events that time
    // the next transition (last pass-1 address, done, last pass-2 issue).
    localparam int P_IDLE = 0, P_P1 = 1, P_WAIT = 2, P_ADR = 3, P_P2 = 4, P_DRN = 5;
    int m_ph = P_IDLE, m_pix = 0, m_t_last = 0, m_t_done = 0, m_t_issue = 0;
    bit m_ale_rst = 0, m_fd = 0, m_err = 0;
    logic [7:0]  m_a[3];
    logic [13:0] m_inv[3];
    bit m_h1[RD_LAT];
    bit m_h2[RD_LAT];

    initial begin
        for (int i = 0; i < NPIX; i++) p2_hits[i] = 0;
        forever begin
            bit e_rd;
            @(negedge clk);
            #3;
            if (!rst) begin
                m_ph = P_IDLE; m_pix = 0; m_ale_rst = 0; m_fd = 0; m_err = 0;
                for (int i = 0; i < 3; i++) begin m_a[i] = '0; m_inv[i] = '0; end
                for (int i = 0; i < RD_LAT; i++) begin m_h1[i] = 0; m_h2[i] = 0; end
            end
            e_rd = rst && !abort && (m_ph == P_P1 || (m_ph == P_P2 && dh_ready));
            chk("rd_en", 32'(rd_en), 32'(e_rd));
            if (e_rd) chk("rd_addr", 32'(rd_addr), 32'(m_pix));
            chk("ale_rst", 32'(ale_rst), 32'(m_ale_rst));
            chk("ale_valid", 32'(ale_valid), 32'(m_h1[RD_LAT-1]));
            chk("dh_valid", 32'(dh_valid), 32'(m_h2[RD_LAT-1]));
            chk("busy", 32'(busy), 32'(m_ph != P_IDLE));
            chk("pass2", 32'(pass2), 32'(m_ph == P_P2 || m_ph == P_DRN));
            chk("frame_done", 32'(frame_done), 32'(m_fd));
            chk("ale_err", 32'(ale_err), 32'(m_err));
            chk("a_r", 32'(a_r), 32'(m_a[0]));
            chk("a_g", 32'(a_g), 32'(m_a[1]));
            chk("a_b", 32'(a_b), 32'(m_a[2]));
            chk("inv_a_r", 32'(inv_a_r), 32'(m_inv[0]));
            chk("inv_a_g", 32'(inv_a_g), 32'(m_inv[1]));
            chk("inv_a_b", 32'(inv_a_b), 32'(m_inv[2]));

            if (ale_rst) mon_rst_cnt++;
            if (rd_en && busy && !pass2) begin
                mon_p1_cnt++;
                if (rd_addr == 0) mon_p1_first = cyc;
                if (32'(rd_addr) == NPIX - 1) mon_p1_last = cyc;
            end
            if (rd_en && pass2) p2_hits[rd_addr]++;
            if (dh_valid) begin mon_dh_cnt++; mon_dh_last = cyc; end
            if (frame_done) begin mon_fd_cnt++; mon_fd_last = cyc; end
            if (ale_err && !prev_err) mon_err_rise = cyc;
            if (ale_done && !prev_done) mon_done_first = cyc;
            if (a_r != prev_a_r) mon_latch_cyc = cyc;
            prev_err = ale_err; prev_done = ale_done; prev_a_r = a_r;

            if (rst) begin
                m_ale_rst = 0; m_fd = 0;
                for (int i = RD_LAT - 1; i > 0; i--) begin m_h1[i] = m_h1[i-1]; m_h2[i] = m_h2[i-1]; end
                m_h1[0] = e_rd && m_ph == P_P1;
                m_h2[0] = e_rd && m_ph == P_P2;
                if (abort && m_ph != P_IDLE) begin
                    m_ph = P_IDLE; m_pix = 0;
                    for (int i = 0; i < RD_LAT; i++) begin m_h1[i] = 0; m_h2[i] = 0; end
                end else begin
                    case (m_ph)
                        P_IDLE: if (start) begin m_ph = P_P1; m_pix = 0; m_ale_rst = 1; m_err = 0; end
                        P_P1: begin
                            m_pix++;
                            if (m_pix == NPIX) begin m_ph = P_WAIT; m_pix = 0; m_t_last = cyc; end
                        end
                        P_WAIT: begin
                            if (ale_done) begin m_ph = P_ADR; m_t_done = cyc; end
                            else if (cyc - m_t_last == TIMEOUT - 1) begin m_err = 1; m_ph = P_IDLE; end
                        end
                        P_ADR: if (cyc - m_t_done == ALE_LAT) begin
                            m_a[0] = ale_a_r; m_a[1] = ale_a_g; m_a[2] = ale_a_b;
                            m_inv[0] = ale_inv_r; m_inv[1] = ale_inv_g; m_inv[2] = ale_inv_b;
                            m_ph = P_P2;
                        end
                        P_P2: if (e_rd) begin
                            m_pix++;
                            if (m_pix == NPIX) begin m_ph = P_DRN; m_pix = 0; m_t_issue = cyc; end
                        end
                        P_DRN: if (cyc - m_t_issue == RD_LAT) begin m_fd = 1; m_ph = P_IDLE; end
                        default: m_ph = P_IDLE;
                    endcase
                end
            end
        end
    end

    initial begin
        int b_rst, b_p1, b_dh, b_fd, bad;
        bit ok, s2, ab;
        rst = 1'b0; start = 1'b0; abort = 1'b0; dh_ready = 1'b0;
        repeat (2) @(negedge clk);
        #4;
        chk("reset busy", 32'(busy), 0);
        chk("reset a_r", 32'(a_r), 0);
        chk("reset ale_err", 32'(ale_err), 0);
        @(negedge clk) rst = 1'b1;
        @(negedge clk);

        // Frame 1: normal; dh_ready toggles; start pulses in pass 1 and pass 2
        b_rst = mon_rst_cnt; b_p1 = mon_p1_cnt; b_dh = mon_dh_cnt; b_fd = mon_fd_cnt;
        start = 1'b1; ok = 0; s2 = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            start = (i == 5);
            if (pass2 && !s2) begin start = 1'b1; s2 = 1; end
            dh_ready = ~dh_ready;
            if (frame_done) begin ok = 1; break; end
        end
        #4;
        chk("f1 frame_done reached", 32'(ok), 1);
        chk("f1 ale_rst pulses", 32'(mon_rst_cnt - b_rst), 1);
        chk("f1 pass1 issues", 32'(mon_p1_cnt - b_p1), 16);
        chk("f1 pass1 consecutive", 32'(mon_p1_last - mon_p1_first), 15);
        chk("f1 latch after done", 32'(mon_latch_cyc - mon_done_first), 3);
        chk("f1 a_r", 32'(a_r), 200);
        chk("f1 a_g", 32'(a_g), 180);
        chk("f1 inv_a_b", 32'(inv_a_b), 102);
        chk("f1 dh_valid count", 32'(mon_dh_cnt - b_dh), 16);
        chk("f1 frame_done count", 32'(mon_fd_cnt - b_fd), 1);
        chk("f1 done after last valid", 32'(mon_fd_last - mon_dh_last), 1);
        bad = 0;
        for (int i = 0; i < NPIX; i++) if (p2_hits[i] != 1) bad++;
        chk("f1 pass2 addrs once each", 32'(bad), 0);

        // Frame 2: ALE never finishes -> timeout
        @(negedge clk);
        en_done = 1'b0; start = 1'b1; ok = 0; b_fd = mon_fd_cnt;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (!busy) begin ok = 1; break; end
        end
        #4;
        chk("f2 returned idle", 32'(ok), 1);
        chk("f2 ale_err set", 32'(ale_err), 1);
        chk("f2 err after last addr", 32'(mon_err_rise - mon_p1_last), 16);
        chk("f2 no frame_done", 32'(mon_fd_cnt - b_fd), 0);
        chk("f2 a_r held", 32'(a_r), 200);

        // Frame 3: abort while pass 2 presents address 7
        @(negedge clk);
        en_done = 1'b1; start = 1'b1; ok = 0; ab = 0; b_fd = mon_fd_cnt;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (ab) begin abort = 1'b0; ok = 1; break; end
            dh_ready = ~dh_ready;
            if (i == 1) chk("f3 start clears ale_err", 32'(ale_err), 0);
            if (pass2 && rd_addr == 4'd7) begin abort = 1'b1; ab = 1; end
        end
        #4;
        chk("f3 abort seen", 32'(ok), 1);
        chk("f3 busy after abort", 32'(busy), 0);
        chk("f3 rd_en after abort", 32'(rd_en), 0);
        chk("f3 a_r unchanged", 32'(a_r), 200);
        chk("f3 inv_a_b unchanged", 32'(inv_a_b), 102);
        chk("f3 no frame_done", 32'(mon_fd_cnt - b_fd), 0);

        // Frame 4: start with abort in IDLE, then async reset at address 9
        @(negedge clk);
        start = 1'b1; abort = 1'b1; ok = 0;
        b_rst = mon_rst_cnt; b_p1 = mon_p1_cnt;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            start = 1'b0; abort = 1'b0;
            if (busy && !pass2 && rd_addr == 4'd9) begin rst = 1'b0; ok = 1; break; end
        end
        #1;
        chk("f4 reached addr 9", 32'(ok), 1);
        chk("f4 async busy", 32'(busy), 0);
        chk("f4 async rd_en", 32'(rd_en), 0);
        chk("f4 async rd_addr", 32'(rd_addr), 0);
        chk("f4 async a_r", 32'(a_r), 0);
        chk("f4 async inv_a_b", 32'(inv_a_b), 0);
        #4;
        chk("f4 start+abort accepted", 32'(mon_rst_cnt - b_rst), 1);
        chk("f4 pass1 issues before rst", 32'(mon_p1_cnt - b_p1), 9);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (4) @(negedge clk);
        #4;
        chk("f4 stays idle", 32'(busy), 0);
        chk("f4 no rd_en", 32'(rd_en), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/haze_frame_sequencer.md
Name: haze_frame_sequencer

Overview:
- Two-pass frame controller for the dehaze pipeline.
- Pass 1: streams every frame-buffer pixel address in raster order so the 3x3 window path feeds the atmospheric light estimator. It then waits for the estimator's done flag and pipeline drain, and latches A_R/G/B and Inv_A_R/G/B.
- Pass 2: re-streams the frame to the transmission/recovery datapath under downstream backpressure, with the latched atmospheric light held constant for the whole pass.
- Sits between the frame buffer read port, the ALE instance and the recovery stage.

Parameters:
IMG_W, 512, image width in pixels
IMG_H, 512, image height in pixels
ADDR_W, 18, frame buffer address width; must satisfy 2^ADDR_W >= IMG_W*IMG_H
RD_LAT, 1, frame buffer read latency in cycles
ALE_LAT, 2, cycles from ale_done rising to final A/Inv_A stable at estimator outputs
TIMEOUT, 16, max cycles after the last pass-1 address to wait for ale_done

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-low reset
start  in  1  frame start request, sampled in IDLE only
abort  in  1  return to IDLE from any busy state
rd_en  out  1  frame buffer read enable
rd_addr  out  ADDR_W  raster read address
ale_rst  out  1  one-cycle active-high reset pulse to the ALE
ale_valid  out  1  input_valid to the ALE (rd_en delayed RD_LAT, pass 1 only)
ale_done  in  1  ALE all-pixels-processed flag
ale_a_r / ale_a_g / ale_a_b  in  8 each  ALE atmospheric light outputs
ale_inv_r / ale_inv_g / ale_inv_b  in  14 each  ALE reciprocal outputs, Q0.14
a_r / a_g / a_b  out  8 each  latched atmospheric light
inv_a_r / inv_a_g / inv_a_b  out  14 each  latched reciprocals, Q0.14
dh_ready  in  1  recovery stage can accept an issue this cycle
dh_valid  out  1  pixel valid to recovery stage (pass-2 rd_en delayed RD_LAT)
busy  out  1  high in every state except IDLE
pass2  out  1  high in DEHAZE and DH_DRAIN
frame_done  out  1  one-cycle pulse at frame completion
ale_err  out  1  sticky timeout flag, cleared on accepted start

Behaviour:
- Reset values: all outputs 0; state IDLE; address counter 0; delay lines cleared.
- IDLE:
  - On start=1: ale_rst=1 for one cycle, clear ale_err, go to ALE_PASS.
  - start in any other state is ignored.
- ALE_PASS:
  - rd_en=1 every cycle; rd_addr increments 0..IMG_W*IMG_H-1.
  - On the cycle issuing the last address, counter wraps to 0, timeout counter clears, go to ALE_WAIT.
  - No backpressure in this pass.
- ALE_WAIT:
  - rd_en=0; wait for ale_done=1, then go to ALE_DRAIN.
  - If TIMEOUT cycles elapse without ale_done: set ale_err, go to IDLE with no frame_done.
- ALE_DRAIN:
  - Count ALE_LAT cycles after ale_done was first seen.
  - On completion, latch all six ALE outputs into a_*/inv_a_* in one cycle, go to DEHAZE.
- DEHAZE:
  - rd_en = dh_ready; address advances only when rd_en=1.
  - dh_ready=0 holds the address (stall, no skip, no duplicate).
  - After the last address is issued, go to DH_DRAIN.
- DH_DRAIN:
  - Wait RD_LAT cycles so the final dh_valid is emitted.
  - Then frame_done=1 for one cycle, go to IDLE.
- Delay lines: ale_valid and dh_valid are rd_en delayed exactly RD_LAT cycles, each gated by the pass that issued it.
- Latched a_*/inv_a_* change only at the ALE_DRAIN latch cycle. They hold through pass 2, IDLE, abort and timeout, and reset only on rst.
- abort=1 in any non-IDLE state:
  - Next state IDLE; rd_en=0 that cycle.
  - Address counter, delay lines and timeout counter cleared. In-flight valid delay lines are flushed.
  - No frame_done.
- Simultaneous abort and a state-advance condition: abort wins. start together with abort in IDLE: start accepted.
- rst asserted mid-frame: immediate return to reset values. No ale_rst pulse is generated; the top level ties the ALE to system reset as well.

Test Plan:
- IMG_W=4, IMG_H=4, RD_LAT=1, ALE model asserts ale_done 1 cycle after the 16th valid with A=(200,180,160), Inv=(82,91,102). Pulse start -> ale_rst pulse, rd_addr 0..15 on 16 consecutive cycles, ale_valid lags rd_en by 1. Latch occurs 2 cycles after ale_done, then a_r=200, inv_a_b=102.
- Same frame, dh_ready toggling 1,0,1,0 -> pass-2 addresses 0..15 each issued exactly once, 16 dh_valid pulses total, frame_done single pulse 1 cycle after the last dh_valid.
- ALE model never asserts ale_done -> ale_err=1 exactly TIMEOUT=16 cycles after address 15, state IDLE, no frame_done. The next start clears ale_err.
- abort at pass-2 address 7 -> rd_en=0 next cycle, busy=0, a_*/inv_a_* unchanged, no frame_done. A new start restarts at address 0 with ale_rst.
- start pulsed during ALE_PASS and DEHAZE -> ignored; address sequence unaffected.
- rst low during ALE_PASS at address 9 -> all outputs 0 asynchronously; after release, stays IDLE until start.
